// File: rtl/my_axi4_lite_mst_cmd_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_if
//  Purpose  : AXI4-Lite signal bundle shared by a master and a slave.
//  Ports    : none (interface); modports mst_port / slv_port give direction.
//  Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_if #(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
);
    logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   awaddr;
    logic                                  awvalid;
    logic                                  awready;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   wdata;
    logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                                  wvalid;
    logic                                  wready;
    logic [1:0]                            bresp;
    logic                                  bvalid;
    logic                                  bready;
    logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   araddr;
    logic                                  arvalid;
    logic                                  arready;
    logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                            rresp;
    logic                                  rvalid;
    logic                                  rready;

    modport mst_port (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slv_port (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/my_axi4_lite_mst_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : my_axi4_lite_mst_cmd
//  Purpose  : Single-outstanding AXI4-Lite master. Turns a valid/ready command
//             stream (read or write) into one AXI4-Lite transaction at a time
//             and returns each completion on a valid/ready response stream.
//  Ports    : i_clk, i_sync_rst      - clock, synchronous active-high reset
//             i_cmd_*  / o_cmd_ready - command stream (is_wr, addr, wdata, wstrb)
//             o_rsp_*  / i_rsp_ready - response stream (is_wr, rdata, resp)
//             if_m_axi4_lite         - AXI4-Lite master port
//  Revision : 1.0 - initial release
// ============================================================================
module my_axi4_lite_mst_cmd #(
    parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
    parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_sync_rst,
    input  logic                                  i_cmd_valid,
    output logic                                  o_cmd_ready,
    input  logic                                  i_cmd_is_wr,
    input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
    input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                                  o_rsp_valid,
    input  logic                                  i_rsp_ready,
    output logic                                  o_rsp_is_wr,
    output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                            o_rsp_resp,
    axi4_lite_if.mst_port                         if_m_axi4_lite
);

    localparam int c_AW = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int c_DW = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int c_SW = AXI4_LITE_DATA_BIT_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [c_AW-1:0]   r_awaddr;
    logic              r_awvalid;
    logic [c_DW-1:0]   r_wdata;
    logic [c_SW-1:0]   r_wstrb;
    logic              r_wvalid;
    logic              r_bready;
    logic [c_AW-1:0]   r_araddr;
    logic              r_arvalid;
    logic              r_rready;
    logic              r_aw_done;
    logic              r_w_done;
    logic              r_rsp_valid;
    logic              r_rsp_is_wr;
    logic [c_DW-1:0]   r_rsp_rdata;
    logic [1:0]        r_rsp_resp;

    logic              w_cmd_hs;
    logic              w_rsp_hs;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_aw_done;
    logic              w_w_done;
    logic              w_b_hs;
    logic              w_ar_hs;
    logic              w_r_hs;

    // Handshakes are formed from registered VALID/READY only, so no VALID
    // ever depends combinationally on a READY.
    assign w_cmd_hs  = i_cmd_valid && (r_state == ST_IDLE);
    assign w_rsp_hs  = r_rsp_valid && i_rsp_ready;
    assign w_aw_hs   = r_awvalid && if_m_axi4_lite.awready;
    assign w_w_hs    = r_wvalid && if_m_axi4_lite.wready;
    assign w_b_hs    = r_bready && if_m_axi4_lite.bvalid;
    assign w_ar_hs   = r_arvalid && if_m_axi4_lite.arready;
    assign w_r_hs    = r_rready && if_m_axi4_lite.rvalid;

    // AW and W complete independently; "done" includes a handshake happening
    // on this very edge so both channels finishing together is handled.
    assign w_aw_done = r_aw_done || w_aw_hs;
    assign w_w_done  = r_w_done || w_w_hs;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_hs) begin
                    w_state_nxt = i_cmd_is_wr ? ST_WR_AW_W : ST_RD_AR;
                end
            end
            ST_WR_AW_W: begin
                if (w_aw_done && w_w_done) begin
                    w_state_nxt = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (w_b_hs) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RD_AR: begin
                if (w_ar_hs) begin
                    w_state_nxt = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (w_r_hs) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                if (w_rsp_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered AXI master outputs and response payload
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_is_wr <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_hs) begin
                        if (i_cmd_is_wr) begin
                            r_awaddr  <= i_cmd_addr;
                            r_wdata   <= i_cmd_wdata;
                            r_wstrb   <= i_cmd_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else begin
                            r_araddr  <= i_cmd_addr;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    r_aw_done <= w_aw_done;
                    r_w_done  <= w_w_done;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                    end
                end
                ST_WR_B: begin
                    if (w_b_hs) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_is_wr <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= if_m_axi4_lite.bresp;
                    end
                end
                ST_RD_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                ST_RD_R: begin
                    if (w_r_hs) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_is_wr <= 1'b0;
                        r_rsp_rdata <= if_m_axi4_lite.rdata;
                        r_rsp_resp  <= if_m_axi4_lite.rresp;
                    end
                end
                ST_RSP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------
    assign o_cmd_ready            = (r_state == ST_IDLE);
    assign o_rsp_valid            = r_rsp_valid;
    assign o_rsp_is_wr            = r_rsp_is_wr;
    assign o_rsp_rdata            = r_rsp_rdata;
    assign o_rsp_resp             = r_rsp_resp;

    assign if_m_axi4_lite.awaddr  = r_awaddr;
    assign if_m_axi4_lite.awvalid = r_awvalid;
    assign if_m_axi4_lite.wdata   = r_wdata;
    assign if_m_axi4_lite.wstrb   = r_wstrb;
    assign if_m_axi4_lite.wvalid  = r_wvalid;
    assign if_m_axi4_lite.bready  = r_bready;
    assign if_m_axi4_lite.araddr  = r_araddr;
    assign if_m_axi4_lite.arvalid = r_arvalid;
    assign if_m_axi4_lite.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_my_axi4_lite_mst_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : tb_my_axi4_lite_mst_cmd
//  Purpose  : Bench for my_axi4_lite_mst_cmd with a 4-register AXI4-Lite
//             slave model, a transaction-level expected-response queue and
//             per-cycle protocol checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_my_axi4_lite_mst_cmd;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_wr;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_is_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    axi4_lite_if #(.AXI4_LITE_ADDR_BIT_WIDTH(32), .AXI4_LITE_DATA_BIT_WIDTH(32)) axi ();

    my_axi4_lite_mst_cmd #(
        .AXI4_LITE_ADDR_BIT_WIDTH(32),
        .AXI4_LITE_DATA_BIT_WIDTH(32)
    ) dut (
        .i_clk          (clk),
        .i_sync_rst     (rst),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_is_wr    (cmd_is_wr),
        .i_cmd_addr     (cmd_addr),
        .i_cmd_wdata    (cmd_wdata),
        .i_cmd_wstrb    (cmd_wstrb),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_is_wr    (rsp_is_wr),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_resp     (rsp_resp),
        .if_m_axi4_lite (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int n_wr  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Slave model: 4 x 32-bit registers at 0x0..0xC, SLVERR elsewhere.
    // Ready delays are counted in cycles of VALID seen high.
    // ------------------------------------------------------------------
    int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0;
    int aw_cnt, w_cnt, ar_cnt, b_cnt;
    int aw_hs_cnt, w_hs_cnt, b_hs_cnt;
    logic        aw_got, w_got;
    logic [31:0] s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_regs [4];

    always @(posedge clk) begin
        if (rst) begin
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            axi.bvalid  <= 1'b0;
            axi.bresp   <= 2'b00;
            axi.arready <= 1'b0;
            axi.rvalid  <= 1'b0;
            axi.rdata   <= '0;
            axi.rresp   <= 2'b00;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0;
            aw_hs_cnt <= 0; w_hs_cnt <= 0; b_hs_cnt <= 0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
            for (int i = 0; i < 4; i++) s_regs[i] <= '0;
        end else begin
            if (axi.awvalid && axi.awready) begin
                axi.awready <= 1'b0; aw_got <= 1'b1; s_awaddr <= axi.awaddr;
                aw_cnt <= 0; aw_hs_cnt <= aw_hs_cnt + 1;
            end else if (axi.awvalid && !aw_got) begin
                if (aw_cnt >= aw_dly) axi.awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (axi.wvalid && axi.wready) begin
                axi.wready <= 1'b0; w_got <= 1'b1; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb;
                w_cnt <= 0; w_hs_cnt <= w_hs_cnt + 1;
            end else if (axi.wvalid && !w_got) begin
                if (w_cnt >= w_dly) axi.wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (axi.bvalid && axi.bready) begin
                axi.bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_cnt <= 0;
                b_hs_cnt <= b_hs_cnt + 1;
            end else if (aw_got && w_got && !axi.bvalid) begin
                if (b_cnt >= b_dly) begin
                    axi.bvalid <= 1'b1;
                    if (s_awaddr < 32'h10) begin
                        axi.bresp <= 2'b00;
                        for (int b = 0; b < 4; b++)
                            if (s_wstrb[b]) s_regs[s_awaddr[3:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                    end else begin
                        axi.bresp <= 2'b10;
                    end
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (axi.arvalid && axi.arready) begin
                axi.arready <= 1'b0; ar_cnt <= 0; axi.rvalid <= 1'b1;
                if (axi.araddr < 32'h10) begin
                    axi.rdata <= s_regs[axi.araddr[3:2]]; axi.rresp <= 2'b00;
                end else begin
                    axi.rdata <= '0; axi.rresp <= 2'b10;
                end
            end else if (axi.arvalid && !axi.rvalid) begin
                if (ar_cnt >= ar_dly) axi.arready <= 1'b1;
                else ar_cnt <= ar_cnt + 1;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: expected response per accepted command, computed
    // from a plain register array, plus per-cycle protocol checks.
    // Everything here is sampled on the falling edge.
    // ------------------------------------------------------------------
    typedef struct {
        logic        is_wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_regs [4];
    bit          have_prev;
    logic        p_awvalid, p_awready, p_wvalid, p_wready, p_arvalid, p_arready;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic        p_rsp_valid, p_rsp_ready, p_acc, p_acc_wr;
    logic [34:0] p_rsp;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                if (p_awvalid && !p_awready) chk("aw_stable", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
                if (p_awvalid && p_awready)  chk("aw_drop", axi.awvalid, 1'b0);
                if (p_wvalid && !p_wready)   chk("w_stable", {axi.wvalid, axi.wstrb, axi.wdata}, {1'b1, p_wstrb, p_wdata});
                if (p_wvalid && p_wready)    chk("w_drop", axi.wvalid, 1'b0);
                if (p_arvalid && !p_arready) chk("ar_stable", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
                if (p_arvalid && p_arready)  chk("ar_drop", axi.arvalid, 1'b0);
                if (p_rsp_valid && !p_rsp_ready)
                    chk("rsp_stable", {rsp_valid, rsp_is_wr, rsp_resp, rsp_rdata}, {1'b1, p_rsp});
                if (p_acc)
                    chk("valid_after_accept", {axi.awvalid, axi.wvalid, axi.arvalid},
                        p_acc_wr ? 3'b110 : 3'b001);
            end
            chk("cmd_ready_vs_busy", cmd_ready && (rsp_valid || axi.awvalid || axi.wvalid ||
                axi.arvalid || axi.bready || axi.rready), 1'b0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
                else chk("rsp_payload", {rsp_is_wr, rsp_resp, rsp_rdata},
                         {exp_q[0].is_wr, exp_q[0].resp, exp_q[0].rdata});
            end
            if (rsp_valid && rsp_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (cmd_valid && cmd_ready) begin
                e.is_wr = cmd_is_wr;
                e.resp  = (cmd_addr < 32'h10) ? 2'b00 : 2'b10;
                e.rdata = '0;
                if (cmd_addr < 32'h10) begin
                    if (cmd_is_wr) begin
                        for (int b = 0; b < 4; b++)
                            if (cmd_wstrb[b]) m_regs[cmd_addr[3:2]][8*b +: 8] = cmd_wdata[8*b +: 8];
                    end else begin
                        e.rdata = m_regs[cmd_addr[3:2]];
                    end
                end
                exp_q.push_back(e);
            end
            p_awvalid = axi.awvalid; p_awready = axi.awready; p_awaddr = axi.awaddr;
            p_wvalid  = axi.wvalid;  p_wready  = axi.wready;  p_wdata  = axi.wdata; p_wstrb = axi.wstrb;
            p_arvalid = axi.arvalid; p_arready = axi.arready; p_araddr = axi.araddr;
            p_rsp_valid = rsp_valid; p_rsp_ready = rsp_ready;
            p_rsp = {rsp_is_wr, rsp_resp, rsp_rdata};
            p_acc = cmd_valid && cmd_ready; p_acc_wr = cmd_is_wr;
            have_prev = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold,
                          output logic [31:0] rd, output logic [1:0] rs, output logic iw);
        int budget;
        rd = '0; rs = '0; iw = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_is_wr = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
        budget = 0;
        while (!cmd_ready && budget < 50) begin @(posedge clk); #1; budget++; end
        if (!cmd_ready) begin
            chk("cmd_accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_addr = 32'hA5A5_A5A5; cmd_wdata = 32'h5A5A_5A5A; cmd_wstrb = 4'h0;
        if (wr) n_wr++;
        budget = 0;
        while (!rsp_valid && budget < 200) begin @(posedge clk); #1; budget++; end
        if (!rsp_valid) begin
            chk("rsp_timeout", 1'b0, 1'b1);
            return;
        end
        for (int i = 0; i < hold; i++) begin
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_no_axi_valid", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b000);
            @(posedge clk); #1;
        end
        rd = rsp_rdata; rs = rsp_resp; iw = rsp_is_wr;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        logic        iw;
        int          budget;
        int          stray;

        rst = 1'b1; cmd_valid = 1'b0; cmd_is_wr = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_valid_ready", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}, 6'b0);
        chk("rst_addr", {axi.awaddr, axi.araddr}, 64'h0);
        chk("rst_wdata_strb", {axi.wstrb, axi.wdata}, 36'h0);
        chk("rst_rsp_payload", {rsp_is_wr, rsp_resp, rsp_rdata}, 35'h0);
        rst = 1'b0;

        // 1: write then read back
        do_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, rd, rs, iw);
        chk("t1_wr_rsp", {iw, rs, rd}, {1'b1, 2'b00, 32'h0});
        do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, rs, iw);
        chk("t1_rd_rsp", {iw, rs, rd}, {1'b0, 2'b00, 32'hDEADBEEF});

        // 2: byte strobes
        do_cmd(1'b1, 32'h8, 32'h0, 4'hF, 0, rd, rs, iw);
        do_cmd(1'b1, 32'h8, 32'h11223344, 4'h5, 0, rd, rs, iw);
        chk("t2_wr_rsp", {iw, rs}, {1'b1, 2'b00});
        do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, rs, iw);
        chk("t2_rd_rdata", rd, 32'h00220044);

        // 3: AW and W complete at different times, both orders
        aw_dly = 0; w_dly = 3;
        do_cmd(1'b1, 32'hC, 32'hCAFEF00D, 4'hF, 0, rd, rs, iw);
        aw_dly = 3; w_dly = 0;
        do_cmd(1'b1, 32'h0, 32'h01234567, 4'hF, 0, rd, rs, iw);
        aw_dly = 0; w_dly = 0; ar_dly = 2;
        chk("t3_aw_beats", aw_hs_cnt, n_wr);
        chk("t3_w_beats", w_hs_cnt, n_wr);
        chk("t3_b_beats", b_hs_cnt, n_wr);
        do_cmd(1'b0, 32'hC, 32'h0, 4'h0, 0, rd, rs, iw);
        chk("t3_rd_rdata", rd, 32'hCAFEF00D);
        ar_dly = 0;

        // 4: response back-pressure
        do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 10, rd, rs, iw);
        chk("t4_rd_rdata", rd, 32'hDEADBEEF);

        // 5: slave error passed through, next command normal
        do_cmd(1'b0, 32'h40, 32'h0, 4'h0, 0, rd, rs, iw);
        chk("t5_err_resp", {iw, rs}, {1'b0, 2'b10});
        do_cmd(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, rs, iw);
        chk("t5_next_rsp", {rs, rd}, {2'b00, 32'h01234567});

        // 6: reset while waiting for B
        b_dly = 30;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_is_wr = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        budget = 0;
        while (!axi.bready && budget < 50) begin @(posedge clk); #1; budget++; end
        chk("t6_reached_wr_b", axi.bready, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid_ready_cleared", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, rsp_valid}, 6'b0);
        chk("t6_cmd_ready", cmd_ready, 1'b1);
        rst = 1'b0; b_dly = 0; rsp_ready = 1'b1;
        stray = 0;
        repeat (40) begin @(posedge clk); #1; if (rsp_valid) stray++; end
        rsp_ready = 1'b0;
        chk("t6_no_response", stray, 0);
        do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, rs, iw);
        chk("t6_after_rst_rd", {rs, rd}, {2'b00, 32'h0});

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        n_mis++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
